// File: rtl/rk2_frame_rx_if.sv
// Beat-level receive bus for rk2_frame_rx: frame select and data in,
// result pulses, error reason and assembled payload out.
interface rk2_frame_rx_if #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 2
);
    logic                      cs;
    logic [DATA_W-1:0]         d_in;
    logic                      ack;
    logic                      err;
    logic [1:0]                err_code;
    logic [DATA_W*BEATS-1:0]   d_out;

    modport master (
        output cs, d_in,
        input  ack, err, err_code, d_out
    );

    modport slave (
        input  cs, d_in,
        output ack, err, err_code, d_out
    );
endinterface

// File: rtl/rk2_frame_rx.sv
// Framed beat receiver: header check, payload assembly, optional XOR checksum,
// one registered ack/err pulse per frame when the frame select goes high.
module rk2_frame_rx #(
    parameter int               DATA_W    = 8,
    parameter int               BEATS     = 2,
    parameter logic [DATA_W-1:0] HEADER   = DATA_W'(8'hCA),
    parameter bit               MSB_FIRST = 1'b1,
    parameter bit               CHECK_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    rk2_frame_rx_if.slave bus
);
    localparam int PW = DATA_W * BEATS;
    localparam int CW = $clog2(BEATS + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_OK   = 3'd1,
        PAYLOAD  = 3'd2,
        CHECK    = 3'd3,
        OVERRUN  = 3'd4,
        BAD_HDR  = 3'd5
    } state_t;

    function automatic logic [DATA_W-1:0] csum_step(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] beat);
        return acc ^ beat;
    endfunction

    function automatic logic [PW-1:0] payload_shift(input logic [PW-1:0] acc,
                                                    input logic [DATA_W-1:0] beat);
        logic [PW-1:0] ext;
        ext = PW'(beat);
        if (MSB_FIRST) begin
            return (acc << DATA_W) | ext;
        end else begin
            return (acc >> DATA_W) | (ext << (PW - DATA_W));
        end
    endfunction

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [DATA_W-1:0] csum_r, csum_s;
    logic [PW-1:0]     shift_r, shift_s;
    logic              chk_got_r, chk_got_s;
    logic              chk_ok_r, chk_ok_s;
    logic              armed_r, armed_s;
    logic              res_ack_s, res_err_s;
    logic [1:0]        res_code_s;

    logic              ack_r, err_r;
    logic [1:0]        err_code_r;
    logic [PW-1:0]     d_out_r;

    // Next-state, frame bookkeeping and result decision for the current beat
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        csum_s     = csum_r;
        shift_s    = shift_r;
        chk_got_s  = chk_got_r;
        chk_ok_s   = chk_ok_r;
        armed_s    = armed_r;
        res_ack_s  = 1'b0;
        res_err_s  = 1'b0;
        res_code_s = 2'd0;

        if (bus.cs) begin
            // A frame ends here; after reset this also arms the receiver.
            armed_s = 1'b1;
            state_s = IDLE;
            case (state_r)
                IDLE: begin
                    res_err_s = 1'b0;
                end
                HDR_OK, PAYLOAD, OVERRUN: begin
                    res_err_s  = 1'b1;
                    res_code_s = 2'd2;
                end
                CHECK: begin
                    if (CHECK_EN && !chk_got_r) begin
                        res_err_s  = 1'b1;
                        res_code_s = 2'd2;
                    end else if (CHECK_EN && !chk_ok_r) begin
                        res_err_s  = 1'b1;
                        res_code_s = 2'd3;
                    end else begin
                        res_ack_s = 1'b1;
                    end
                end
                BAD_HDR: begin
                    res_err_s  = 1'b1;
                    res_code_s = 2'd1;
                end
                default: begin
                    res_err_s = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (!armed_r) begin
                        state_s = IDLE;
                    end else if (bus.d_in == HEADER) begin
                        state_s   = HDR_OK;
                        csum_s    = bus.d_in;
                        cnt_s     = CW'(0);
                        shift_s   = PW'(0);
                        chk_got_s = 1'b0;
                        chk_ok_s  = 1'b0;
                    end else begin
                        state_s = BAD_HDR;
                    end
                end
                HDR_OK, PAYLOAD: begin
                    shift_s = payload_shift(shift_r, bus.d_in);
                    csum_s  = csum_step(csum_r, bus.d_in);
                    cnt_s   = cnt_r + CW'(1);
                    if (cnt_r == CW'(BEATS - 1)) begin
                        state_s = CHECK;
                    end else begin
                        state_s = PAYLOAD;
                    end
                end
                CHECK: begin
                    // CHECK doubles as "payload complete" when there is no checksum beat.
                    if (CHECK_EN && !chk_got_r) begin
                        chk_got_s = 1'b1;
                        chk_ok_s  = (bus.d_in == csum_r);
                    end else begin
                        state_s = OVERRUN;
                    end
                end
                OVERRUN, BAD_HDR: begin
                    state_s = state_r;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Frame state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CW'(0);
            csum_r    <= DATA_W'(0);
            shift_r   <= PW'(0);
            chk_got_r <= 1'b0;
            chk_ok_r  <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            csum_r    <= csum_s;
            shift_r   <= shift_s;
            chk_got_r <= chk_got_s;
            chk_ok_r  <= chk_ok_s;
            armed_r   <= armed_s;
        end
    end

    // Registered result pulses; d_out and err_code hold until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'd0;
            d_out_r    <= PW'(0);
        end else begin
            ack_r <= res_ack_s;
            err_r <= res_err_s;
            if (res_ack_s) begin
                d_out_r    <= shift_r;
                err_code_r <= 2'd0;
            end else if (res_err_s) begin
                err_code_r <= res_code_s;
            end
        end
    end

    assign bus.ack      = ack_r;
    assign bus.err      = err_r;
    assign bus.err_code = err_code_r;
    assign bus.d_out    = d_out_r;
endmodule

// File: tb/tb_rk2_frame_rx.sv
// Scoreboard bench for rk2_frame_rx: three parameterisations, expected
// results queued at stimulus time and matched against each result pulse.
module tb_rk2_frame_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rk2_frame_rx_if #(.DATA_W(8), .BEATS(2)) if0 ();
    rk2_frame_rx_if #(.DATA_W(8), .BEATS(2)) if1 ();
    rk2_frame_rx_if #(.DATA_W(8), .BEATS(4)) if2 ();

    rk2_frame_rx dut0 (.clk(clk), .rst(rst), .bus(if0));
    rk2_frame_rx #(.MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    rk2_frame_rx #(.BEATS(4), .CHECK_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic       cs_v [3];
    logic [7:0] d_v  [3];
    assign if0.cs = cs_v[0]; assign if0.d_in = d_v[0];
    assign if1.cs = cs_v[1]; assign if1.d_in = d_v[1];
    assign if2.cs = cs_v[2]; assign if2.d_in = d_v[2];

    logic        ack_w  [3];
    logic        err_w  [3];
    logic [1:0]  code_w [3];
    logic [31:0] dout_w [3];
    assign ack_w[0] = if0.ack; assign err_w[0] = if0.err; assign code_w[0] = if0.err_code; assign dout_w[0] = 32'(if0.d_out);
    assign ack_w[1] = if1.ack; assign err_w[1] = if1.err; assign code_w[1] = if1.err_code; assign dout_w[1] = 32'(if1.d_out);
    assign ack_w[2] = if2.ack; assign err_w[2] = if2.err; assign code_w[2] = if2.err_code; assign dout_w[2] = 32'(if2.d_out);

    typedef struct packed {
        logic [1:0]  dut;
        logic        is_ack;
        logic [1:0]  code;
        logic [31:0] dout;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   total = 0;
    int   bad   = 0;

    // Scoreboard monitor: every result pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ack_w[i] && err_w[i]) begin
                    total++; bad++;
                    $display("FAIL both_pulses dut%0d got ack=1 err=1 required exactly one", i);
                end else if (ack_w[i] || err_w[i]) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse dut%0d got ack=%0b err=%0b required no pulse", i, ack_w[i], err_w[i]);
                    end else begin
                        e_m = sb.pop_front();
                        if (e_m.dut !== 2'(i) || ack_w[i] !== e_m.is_ack || err_w[i] !== !e_m.is_ack ||
                            code_w[i] !== e_m.code || dout_w[i] !== e_m.dout) begin
                            bad++;
                            $display("FAIL result dut%0d got ack=%0b code=%0d dout=%h required dut%0d ack=%0b code=%0d dout=%h",
                                     i, ack_w[i], code_w[i], dout_w[i], e_m.dut, e_m.is_ack, e_m.code, e_m.dout);
                        end
                    end
                end
            end
        end
    end

    task automatic beat(input int i, input logic c, input logic [7:0] d);
        cs_v[i] = c;
        d_v[i]  = d;
        @(posedge clk);
        #1;
    endtask

    // Drives n beats (first beat in the top used byte of bv) then one cs=1 beat
    task automatic frame(input int i, input int n, input logic [63:0] bv, input logic has_res,
                         input logic is_ack, input logic [1:0] code, input logic [31:0] dout);
        if (has_res) sb.push_back({2'(i), is_ack, code, dout});
        for (int k = 0; k < n; k++) beat(i, 1'b0, 8'(bv >> (8 * (n - 1 - k))));
        beat(i, 1'b1, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin cs_v[i] = 1'b1; d_v[i] = 8'h00; end
        rst = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ack_w[i] !== 1'b0 || err_w[i] !== 1'b0 || code_w[i] !== 2'd0 || dout_w[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_state dut%0d got ack=%0b err=%0b code=%0d dout=%h required all 0",
                         i, ack_w[i], err_w[i], code_w[i], dout_w[i]);
            end
        end
        rst = 1'b0;
        idle(4);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL reset_idle pending=%0d required=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_errors;
        frame(0, 4, 64'hCAFF0134,   1'b1, 1'b1, 2'd0, 32'h0000FF01);
        frame(0, 3, 64'hCAFF01,     1'b1, 1'b0, 2'd2, 32'h0000FF01);
        idle(3);
        total++;
        if (code_w[0] !== 2'd2 || dout_w[0] !== 32'h0000FF01) begin
            bad++;
            $display("FAIL short_hold got code=%0d dout=%h required code=2 dout=0000ff01", code_w[0], dout_w[0]);
        end
        frame(0, 4, 64'hCC112233,   1'b1, 1'b0, 2'd1, 32'h0000FF01);
        frame(0, 4, 64'hCA123400,   1'b1, 1'b0, 2'd3, 32'h0000FF01);
        frame(0, 5, 64'hCAFF013455, 1'b1, 1'b0, 2'd2, 32'h0000FF01);
        frame(0, 6, 64'hCC1122334455, 1'b1, 1'b0, 2'd1, 32'h0000FF01);
        frame(0, 1, 64'hCA,         1'b1, 1'b0, 2'd2, 32'h0000FF01);
        idle(3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL errors_drain pending=%0d required=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_lsb_and_wide;
        frame(1, 4, 64'hCAFF0134,   1'b1, 1'b1, 2'd0, 32'h000001FF);
        frame(2, 5, 64'hCA11223344, 1'b1, 1'b1, 2'd0, 32'h11223344);
        frame(2, 4, 64'hCA112233,   1'b1, 1'b0, 2'd2, 32'h11223344);
        frame(2, 6, 64'hCA1122334455, 1'b1, 1'b0, 2'd2, 32'h11223344);
        idle(3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL wide_drain pending=%0d required=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back;
        frame(0, 4, 64'hCA1234EC, 1'b1, 1'b1, 2'd0, 32'h00001234);
        frame(0, 4, 64'hCAABCDAC, 1'b1, 1'b1, 2'd0, 32'h0000ABCD);
        frame(1, 4, 64'hCA1234EC, 1'b1, 1'b1, 2'd0, 32'h00003412);
        frame(1, 4, 64'hCAABCDAC, 1'b1, 1'b1, 2'd0, 32'h0000CDAB);
        idle(3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain pending=%0d required=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_midframe;
        beat(2, 1'b0, 8'hCA);
        beat(2, 1'b0, 8'h11);
        d_v[2] = 8'h22;
        #2 rst = 1'b1;
        #1;
        total++;
        if (ack_w[2] !== 1'b0 || err_w[2] !== 1'b0 || code_w[2] !== 2'd0 || dout_w[2] !== 32'd0) begin
            bad++;
            $display("FAIL midframe_reset got ack=%0b err=%0b code=%0d dout=%h required all 0",
                     ack_w[2], err_w[2], code_w[2], dout_w[2]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        frame(2, 5, 64'hCA11223344, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(3);
        total++;
        if (sb.size() != 0 || dout_w[2] !== 32'd0 || code_w[2] !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_ignore got pending=%0d dout=%h code=%0d required 0 0 0", sb.size(), dout_w[2], code_w[2]);
            sb.delete();
        end
        frame(2, 5, 64'hCA55667788, 1'b1, 1'b1, 2'd0, 32'h55667788);
        idle(3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rearm_drain pending=%0d required=0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_errors();
        test_lsb_and_wide();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rk2_frame_rx.md
RK2_FRAME_RX -- requirements
Module: rk2_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the beat width of d_in in bits.
REQ-002 Parameter BEATS, default 2, range 1..8, SHALL set the number of payload beats per frame.
REQ-003 Parameter HEADER, default 8'hCA (DATA_W bits), SHALL set the required first beat of every frame.
REQ-004 Parameter MSB_FIRST, default 1, SHALL select the payload order: 1 = first payload beat lands in the most significant DATA_W bits of d_out; 0 = it lands in the least significant bits.
REQ-005 Parameter CHECK_EN, default 1, SHALL add one XOR checksum beat after the payload when 1; when 0 the frame has no checksum beat.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 cs  input  1  active-low frame select; one beat is sampled per rising clk edge while cs=0.
REQ-009 d_in  input  DATA_W  beat data.
REQ-010 ack  output  1  one-cycle pulse: frame accepted.
REQ-011 err  output  1  one-cycle pulse: frame rejected.
REQ-012 err_code  output  2  reason for the last err: 0 none, 1 header, 2 length, 3 checksum.
REQ-013 d_out  output  DATA_W*BEATS  last accepted payload word.

Function
REQ-014 Frame SHALL be defined as every beat sampled while cs=0, delimited by the first edge that samples cs=1; expected length N = 1 + BEATS + CHECK_EN.
REQ-015 FSM states SHALL be IDLE, HDR_OK, PAYLOAD, CHECK, OVERRUN, and BAD_HDR.
REQ-016 IDLE with cs=0 SHALL go to HDR_OK if d_in==HEADER, otherwise to BAD_HDR.
REQ-017 HDR_OK/PAYLOAD SHALL shift each beat into a payload shift register in the order set by MSB_FIRST, and count beats with a counter of width clog2(BEATS+1).
REQ-018 After BEATS payload beats, the FSM SHALL go to CHECK (CHECK_EN=1), or treat the frame as complete (CHECK_EN=0).
REQ-019 Running checksum SHALL be the XOR of the header and all payload beats; the checksum beat SHALL equal it.
REQ-020 Any beat beyond N SHALL move the FSM to OVERRUN, and further beats SHALL be ignored; the counter SHALL saturate without wrapping.
REQ-021 BAD_HDR SHALL ignore all beats until cs=1.
REQ-022 On the edge sampling cs=1 in any state other than IDLE, the block SHALL emit exactly one result: ack=1 or err=1, valid in the following cycle for one cycle, then return to IDLE.
REQ-023 Error priority SHALL be header (1) > length, short or overrun (2) > checksum mismatch (3).
REQ-024 On ack, d_out SHALL load the assembled payload and err_code SHALL be set to 0; on err, d_out SHALL hold its previous value and err_code SHALL be set to the reason.
REQ-025 err_code SHALL hold its value until the next result.
REQ-026 cs high in IDLE SHALL produce no pulse.
REQ-027 A new frame beginning on the edge right after a result edge (cs high for a single cycle) SHALL be accepted; ack/err of the previous frame SHALL coincide with the new header sample without loss.
REQ-028 ack and err SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL asynchronously force the FSM to IDLE and clear the counter, checksum and shift register, and force ack=0, err=0, err_code=0, d_out=0.
REQ-030 rst asserted mid-frame SHALL abort the frame silently, with no ack/err; after release, beats SHALL be ignored until cs has been sampled high once.

Verification
REQ-031 Defaults, cs=0 beats CA,FF,01,34 then cs=1 -> ack pulse, d_out=16'hFF01, err_code=0.
REQ-032 Defaults, beats CA,FF,01 (no checksum) then cs=1 -> err, err_code=2, d_out unchanged at 16'hFF01.
REQ-033 Defaults, beats CC,xx,xx,xx then cs=1 -> err, err_code=1; beats CA,12,34,00 -> err, err_code=3.
REQ-034 Defaults, beats CA,FF,01,34,55 -> err, err_code=2; MSB_FIRST=0 with CA,FF,01,34 -> ack, d_out=16'h01FF.
REQ-035 BEATS=4, CHECK_EN=0, beats CA,11,22,33,44 -> ack, d_out=32'h11223344; rst pulse after the second beat -> no pulse, all outputs 0.
REQ-036 Back-to-back frames separated by a single cs=1 cycle -> two acks, the second d_out matching the second frame.
